// File: rtl/bram_stream_reader.sv
// Reads a contiguous block of words from BRAM port B and streams them out as valid/ready beats.
// A 2-entry FIFO absorbs the 1-cycle BRAM read latency so the stream can run at one word per cycle.
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued;
    logic [ADDR_WIDTH:0]     accepted;
    logic [ADDR_WIDTH-1:0]   addr_hold;
    logic                    inflight;

    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_count;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    accept_cmd;
    logic [2:0]              occupancy;
    logic [ADDR_WIDTH-1:0]   issue_addr;

    assign pop        = m_valid & m_ready;
    assign push       = inflight;
    assign accept_cmd = (state == IDLE) && start;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue_addr = base_q + issued[ADDR_WIDTH-1:0];

    // A read may only be launched if its data is guaranteed a FIFO slot when it lands,
    // counting the word already in flight and crediting a pop happening this cycle.
    assign issue = (state == RUN) && (issued < len_q) && (occupancy < (3'd2 + {2'b00, pop}));

    assign bram_en   = issue;
    assign bram_addr = issue ? issue_addr : addr_hold;
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = fifo_mem[rd_ptr];
    assign m_last    = m_valid && (accepted == (len_q - CNT_ONE));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && m_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            accepted  <= '0;
            addr_hold <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                addr_hold <= issue_addr;
            end
            if (accept_cmd) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + CNT_ONE;
                end
                if (pop) begin
                    accepted <= accepted + CNT_ONE;
                end
            end
        end
    end

    // Read data is captured the cycle after the read is issued, so push is simply the delayed enable.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a BRAM model feeds port B, expected addresses and beats
// are queued as each command is issued and a negedge monitor pops and compares them.
module tb_bram_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } rd_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;

    logic [DW-1:0] mem [DEPTH];
    beat_t         exp_beats[$];
    rd_t           exp_reads[$];

    int            vec_count = 0;
    int            miscompares = 0;
    int            cyc_num = 0;
    int            start_cyc = 0;
    int            issue_cnt = 0;
    int            beat_cnt = 0;
    int            done_cnt = 0;
    bit            bp_mode = 1'b0;
    int            bp_idx = 0;
    bit            bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc_num <= cyc_num + 1;

    always @(posedge ACLK) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void report_unexpected(input string name, input logic [63:0] act);
        vec_count++;
        miscompares++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
    endfunction

    function automatic void push_expected(input logic [AW-1:0] b, input logic [AW:0] l, input bit timed);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_reads.push_back('{addr: a, cyc: timed ? 1 + i : -1});
            exp_beats.push_back('{data: mem[a], last: (i == int'(l) - 1), cyc: timed ? 3 + i : -1});
        end
    endfunction

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (bp_mode) begin
                m_ready = bp_pat[bp_idx % 6];
                bp_idx++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: sampled mid-cycle, so every handshake seen here completes at the next rising edge.
    always @(negedge ACLK) begin
        beat_t e;
        rd_t   r;
        int    rel;
        rel = cyc_num - start_cyc;
        if (busy) check_output("occupancy_le2", 64'((issue_cnt - beat_cnt) <= 2), 64'd1);
        if (prev_stall) begin
            check_output("stall_valid", m_valid, 1);
            check_output("stall_data", m_data, prev_data);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (bram_en) begin
            if (exp_reads.size() == 0) begin
                report_unexpected("unexpected_read", bram_addr);
            end else begin
                r = exp_reads.pop_front();
                check_output("read_addr", bram_addr, r.addr);
                if (r.cyc >= 0) check_output("read_cycle", rel, r.cyc);
            end
            issue_cnt++;
        end
        if (m_valid && m_ready) begin
            if (exp_beats.size() == 0) begin
                report_unexpected("unexpected_beat", m_data);
            end else begin
                e = exp_beats.pop_front();
                check_output("beat_data", m_data, e.data);
                check_output("beat_last", m_last, e.last);
                if (e.cyc >= 0) check_output("beat_cycle", rel, e.cyc);
            end
            beat_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic apply_stimulus(input logic [AW-1:0] b, input logic [AW:0] l, input int exp_done,
                                  input bit bp, input bit dup);
        int k;
        bit seen;
        int done_before;
        push_expected(b, l, !bp);
        done_before = done_cnt;
        bp_mode = bp;
        bp_idx  = 0;
        @(posedge ACLK);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        start_cyc = cyc_num;
        @(negedge ACLK);
        check_output("busy_cycle0", busy, 0);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 2000) begin
            @(posedge ACLK);
            #1;
            k++;
            start     = dup && (k == 2);
            base_addr = (dup && k == 2) ? AW'(100) : '0;
            length    = (dup && k == 2) ? (AW + 1)'(2) : '0;
            @(negedge ACLK);
            check_output("busy_running", busy, 1);
            if (done) begin
                seen = 1'b1;
                if (exp_done >= 0) check_output("done_cycle", k, exp_done);
            end
        end
        if (!seen) report_unexpected("done_timeout", k);
        @(negedge ACLK);
        check_output("busy_after_done", busy, 0);
        check_output("done_single_cycle", done, 0);
        repeat (3) @(negedge ACLK);
        check_output("done_count", done_cnt - done_before, 1);
        check_output("beats_left", exp_beats.size(), 0);
        check_output("reads_left", exp_reads.size(), 0);
        bp_mode = 1'b0;
    endtask

    task automatic reset_mid_block();
        int beats_before;
        int done_before;
        int k;
        push_expected(AW'(16), (AW + 1)'(8), 1'b1);
        beats_before = beat_cnt;
        @(posedge ACLK);
        #1;
        start     = 1'b1;
        base_addr = AW'(16);
        length    = (AW + 1)'(8);
        start_cyc = cyc_num;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        k = 0;
        while ((beat_cnt - beats_before) < 2 && k < 50) begin
            @(negedge ACLK);
            k++;
        end
        check_output("beats_before_reset", beat_cnt - beats_before, 2);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        #1;
        check_output("reset_mid_outputs", {busy, done, bram_en, m_valid, m_last, bram_addr, m_data}, '0);
        exp_beats.delete();
        exp_reads.delete();
        issue_cnt   = 0;
        beat_cnt    = 0;
        prev_stall  = 1'b0;
        done_before = done_cnt;
        repeat (4) @(negedge ACLK);
        check_output("no_done_in_reset", done_cnt - done_before, 0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check_output("no_done_after_reset", done_cnt - done_before, 0);
        check_output("idle_after_reset", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hD000_0000 + 32'(i);
        mem[0] = 32'h1;
        mem[1] = 32'h2;
        mem[2] = 32'h3;
        mem[3] = 32'h4;
        #12;
        check_output("reset_outputs", {busy, done, bram_en, m_valid, m_last, bram_addr, m_data}, '0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        $display("[TB] full-rate read");
        apply_stimulus(AW'(0), (AW + 1)'(4), 7, 1'b0, 1'b0);
        $display("[TB] backpressure");
        apply_stimulus(AW'(0), (AW + 1)'(4), -1, 1'b1, 1'b0);
        $display("[TB] zero length");
        apply_stimulus(AW'(5), (AW + 1)'(0), 1, 1'b0, 1'b0);
        $display("[TB] address wrap");
        apply_stimulus(AW'(1022), (AW + 1)'(4), 7, 1'b0, 1'b0);
        $display("[TB] start while busy");
        apply_stimulus(AW'(0), (AW + 1)'(4), 7, 1'b0, 1'b1);
        $display("[TB] reset mid-block");
        reset_mid_block();
        apply_stimulus(AW'(40), (AW + 1)'(2), 5, 1'b0, 1'b0);
        $display("[TB] full memory");
        apply_stimulus(AW'(512), (AW + 1)'(DEPTH), 3 + DEPTH, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Downstream consumer of the AXI-to-BRAM peripheral; attaches to the second BRAM port (port B) of the shared buffer that host software fills over AXI4-Lite.
- On a start command, reads a contiguous block of words from BRAM and presents them to the simplex datapath as a valid/ready stream, with m_last on the final word.
- Hides the 1-cycle BRAM read latency with a 2-entry output FIFO, sustaining 1 word/cycle when m_ready stays high.

Parameters:
- DATA_WIDTH, 32, BRAM word and stream data width.
- ADDR_WIDTH, 10, BRAM word-address width; word index = AXI byte address >> 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous reset, active-low.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; captured with start.
- length  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- bram_en  out  1  BRAM port-B read enable.
- bram_addr  out  ADDR_WIDTH  BRAM port-B word address.
- bram_dout  in  DATA_WIDTH  BRAM read data, valid the cycle after bram_en.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data; driven from the FIFO head.
- m_last  out  1  high with the final word of the block.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (ARESETN low, asynchronous): state=IDLE; busy, done, bram_en, m_valid, m_last=0; bram_addr=0; m_data=0; FIFO empty; issued count, accepted count and in-flight flag cleared.
- Reset mid-block: the block is abandoned with no partial beats or done afterwards. The next start after reset is a fresh command.
- FSM states:
  - IDLE: start=1 and length≠0 -> RUN; captures base_addr and length, clears counters.
  - IDLE: start=1 and length=0 -> FINISH; no BRAM read.
  - RUN: handshake of the word with m_last -> FINISH.
  - FINISH: done=1 for exactly one cycle -> IDLE.
- busy=1 in RUN and FINISH. start is ignored outside IDLE.
- Issue rule (RUN): assert bram_en with bram_addr = (base + issued) mod 2^ADDR_WIDTH when both hold:
  - issued < length;
  - fifo_count + inflight − pop < 2, where pop = m_valid & m_ready this cycle.
- On issue, issued increments. inflight=1 for the following cycle; in that cycle bram_dout is written into the FIFO.
- The FIFO never overflows; a simultaneous push and pop keeps the count unchanged.
- Stream rules:
  - m_valid = FIFO not empty.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - A beat transfers on m_valid & m_ready.
  - m_last = m_valid and (accepted == length−1).
- Latency: start accepted in cycle 0 -> bram_en in cycle 1 -> FIFO write at the end of cycle 2 -> m_valid in cycle 3.
- With m_ready held high, beats occur on consecutive cycles 3 .. 3+length−1.
- done pulses in the cycle after the m_last handshake.
- Address wrap: bram_addr wraps modulo 2^ADDR_WIDTH with no error.
- length=2^ADDR_WIDTH reads the full memory exactly once.
- Counters are ADDR_WIDTH+1 bits wide, so length compares never overflow.
- bram_en is 0 in IDLE and FINISH; bram_addr holds its last value when bram_en=0.

Test Plan:
- Full-rate read: preload words 0..3 with 0x1,0x2,0x3,0x4; base=0, length=4, m_ready=1.
  -> bram_en in cycles 1-4 with addresses 0,1,2,3; beats 0x1..0x4 in cycles 3-6; m_last only on 0x4; done in cycle 7; busy 1-7.
- Backpressure: same data, m_ready toggling 1,0,0,1,0,1,...
  -> exactly four beats in order 0x1..0x4, no duplicates or drops; m_data stable while stalled; fifo_count+inflight never exceeds 2.
- Zero length: start with length=0.
  -> no bram_en; busy=1 and done=1 in cycle 1; m_valid stays 0.
- Address wrap: ADDR_WIDTH=10, base=1022, length=4.
  -> bram_addr sequence 1022,1023,0,1; data returned in that order; m_last on the 4th beat.
- Start while busy: second start pulse with different base/length during RUN.
  -> ignored; the original block completes unchanged with a single done.
- Reset mid-block: ARESETN low after the 2nd beat of a length-8 read.
  -> all outputs 0 immediately; no further beats or done; a subsequent start with length=2 returns the correct two words.
